counter_ctrl: RTL and testbench

Command-driven controller that sequences a 4-bit up-counter datapath: a host starts, restarts or stops counting through a valid/ready command port, and the block owns the count register, a programmable prescaler and the terminal-count logic. It sits between software-visible control registers and any logic consuming `q` or the terminal-count strobe. It supports one-shot and periodic (auto-reload) modes.

---
 rtl/counter_ctrl_pkg.sv | 24 ++
 rtl/counter_ctrl_tick_prescaler.sv | 44 ++++
 rtl/counter_ctrl.sv | 126 ++++++++++++
 tb/tb_counter_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the command-driven counter controller.
// Imported by the top level and by the prescaler sub-module.
package counter_ctrl_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        OP_NOP            = 2'b00,
        OP_START_ONESHOT  = 2'b01,
        OP_START_PERIODIC = 2'b10,
        OP_STOP           = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic is_start(input cmd_op_e op);
        return (op == OP_START_ONESHOT) || (op == OP_START_PERIODIC);
    endfunction

endpackage

// File: rtl/counter_ctrl_tick_prescaler.sv
// Programmable divider: raises step once every P+1 enabled cycles.
// clr has priority over en and returns the divider to zero.
module tick_prescaler
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] p,
    output logic             step
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign step = en && (cnt_q == p);

    // Next divider value
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {WIDTH{1'b0}};
        end else if (step) begin
            cnt_d = {WIDTH{1'b0}};
        end else if (en) begin
            cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Divider register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= {WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// Command-driven 4-bit up-counter controller with one-shot and periodic modes.
// Owns the FSM, the count register, latched limit/prescale/mode and tc strobe.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_limit,
    input  logic [WIDTH-1:0] cmd_prescale,
    output logic [WIDTH-1:0] q,
    output logic             running,
    output logic             tc_pulse,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [WIDTH-1:0] pre_q, pre_d;
    logic             periodic_q, periodic_d;
    logic             tc_q, tc_d;
    logic             running_q, running_d;
    logic             done_q, done_d;

    cmd_op_e          op_s;
    logic             start_s;
    logic             stop_s;
    logic             step_s;
    logic             pre_en_s;

    assign cmd_ready = 1'b1;
    assign op_s      = cmd_op_e'(cmd_op);
    assign start_s   = cmd_valid && is_start(op_s);
    assign stop_s    = cmd_valid && (op_s == OP_STOP);
    // A STOP in RUN must not advance the divider on the same edge.
    assign pre_en_s  = (state_q == ST_RUN) && !stop_s;

    tick_prescaler #(.WIDTH(WIDTH)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (start_s),
        .en    (pre_en_s),
        .p     (pre_q),
        .step  (step_s)
    );

    // Next-state, count and terminal-count logic; commands outrank steps
    always_comb begin
        state_d    = state_q;
        q_d        = q_q;
        limit_d    = limit_q;
        pre_d      = pre_q;
        periodic_d = periodic_q;
        tc_d       = 1'b0;
        if (start_s) begin
            limit_d    = cmd_limit;
            pre_d      = cmd_prescale;
            periodic_d = (op_s == OP_START_PERIODIC);
            q_d        = {WIDTH{1'b0}};
            state_d    = ST_RUN;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_DONE: state_d = ST_DONE;
                ST_RUN: begin
                    if (stop_s) begin
                        state_d = ST_IDLE;
                    end else if (step_s) begin
                        if (q_q != limit_q) begin
                            q_d = q_q + {{(WIDTH-1){1'b0}}, 1'b1};
                        end else begin
                            tc_d = 1'b1;
                            if (periodic_q) begin
                                q_d = {WIDTH{1'b0}};
                            end else begin
                                state_d = ST_DONE;
                            end
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    q_d     = {WIDTH{1'b0}};
                end
            endcase
        end
        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    // Controller registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            q_q        <= {WIDTH{1'b0}};
            limit_q    <= {WIDTH{1'b0}};
            pre_q      <= {WIDTH{1'b0}};
            periodic_q <= 1'b0;
            tc_q       <= 1'b0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            q_q        <= q_d;
            limit_q    <= limit_d;
            pre_q      <= pre_d;
            periodic_q <= periodic_d;
            tc_q       <= tc_d;
            running_q  <= running_d;
            done_q     <= done_d;
        end
    end

    assign q        = q_q;
    assign running  = running_q;
    assign tc_pulse = tc_q;
    assign done     = done_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed, table-driven bench for counter_ctrl with hand-computed expectations.
// Each row is applied before a rising edge and checked 1 ns after it.
module tb_counter_ctrl;
    import counter_ctrl_pkg::*;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_limit;
    logic [3:0] cmd_prescale;
    logic [3:0] q;
    logic       running;
    logic       tc_pulse;
    logic       done;

    int total;
    int bad;

    typedef struct {
        logic       v;
        logic [1:0] op;
        logic [3:0] lim;
        logic [3:0] pre;
        logic [3:0] eq;
        logic       er;
        logic       etc;
        logic       ed;
    } vec_t;

    vec_t vecs[$];

    counter_ctrl #(.WIDTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_limit    (cmd_limit),
        .cmd_prescale (cmd_prescale),
        .q            (q),
        .running      (running),
        .tc_pulse     (tc_pulse),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] eq, input logic er,
                             input logic etc, input logic ed);
        check({tag, ".q"}, int'(q), int'(eq));
        check({tag, ".running"}, int'(running), int'(er));
        check({tag, ".tc_pulse"}, int'(tc_pulse), int'(etc));
        check({tag, ".done"}, int'(done), int'(ed));
    endtask

    task automatic add(input logic v, input logic [1:0] op, input logic [3:0] lim,
                       input logic [3:0] pre, input logic [3:0] eq, input logic er,
                       input logic etc, input logic ed);
        vec_t t;
        t.v = v; t.op = op; t.lim = lim; t.pre = pre;
        t.eq = eq; t.er = er; t.etc = etc; t.ed = ed;
        vecs.push_back(t);
    endtask

    task automatic step_cmd(input logic v, input logic [1:0] op, input logic [3:0] lim,
                            input logic [3:0] pre);
        @(negedge clk);
        cmd_valid    = v;
        cmd_op       = op;
        cmd_limit    = lim;
        cmd_prescale = pre;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_limit = 4'd0; cmd_prescale = 4'd0;

        // One-shot L=3 P=0, then STOP while DONE
        add(1'b1, 2'b01, 4'd3, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b00, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b00, 4'd0, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b00, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b00, 4'd0, 4'd0, 4'd3, 1'b0, 1'b1, 1'b1);
        add(1'b0, 2'b00, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b1);
        add(1'b1, 2'b11, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b1);
        // Periodic L=2 P=1: q 0,0,1,1,2,2,0,0,1
        add(1'b1, 2'b10, 4'd2, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b00, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b00, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b00, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b00, 4'd0, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b00, 4'd0, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b00, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 2'b00, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b00, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0);
        // Periodic L=0 P=0: terminal step on every edge
        add(1'b1, 2'b10, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b00, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 2'b00, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 2'b00, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        // One-shot L=9 P=0, STOP at q=4, ignored START without valid, restart
        add(1'b1, 2'b01, 4'd9, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b00, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b00, 4'd0, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b00, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b00, 4'd0, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0);
        add(1'b1, 2'b11, 4'd0, 4'd0, 4'd4, 1'b0, 1'b0, 1'b0);
        add(1'b0, 2'b00, 4'd0, 4'd0, 4'd4, 1'b0, 1'b0, 1'b0);
        add(1'b0, 2'b01, 4'd9, 4'd0, 4'd4, 1'b0, 1'b0, 1'b0);
        add(1'b1, 2'b01, 4'd9, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        // Periodic L=1 P=0, restart as one-shot L=2 P=1 on the terminal edge
        add(1'b1, 2'b10, 4'd1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b00, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0);
        add(1'b1, 2'b01, 4'd2, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b00, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b00, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b00, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b00, 4'd0, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b00, 4'd0, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b00, 4'd0, 4'd0, 4'd2, 1'b0, 1'b1, 1'b1);
        add(1'b0, 2'b00, 4'd0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b1);

        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 4'd0, 1'b0, 1'b0, 1'b0);
        check("cmd_ready", int'(cmd_ready), 1);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step_cmd(vecs[i].v, vecs[i].op, vecs[i].lim, vecs[i].pre);
            check_all($sformatf("vec%0d", i), vecs[i].eq, vecs[i].er, vecs[i].etc, vecs[i].ed);
        end

        // Asynchronous reset mid-count at q=5
        step_cmd(1'b1, 2'b10, 4'd9, 4'd0);
        for (int i = 0; i < 5; i++) step_cmd(1'b0, 2'b00, 4'd0, 4'd0);
        check_all("pre_reset", 4'd5, 1'b1, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_all("async_reset", 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step_cmd(1'b0, 2'b00, 4'd0, 4'd0);
        check_all("post_reset_idle", 4'd0, 1'b0, 1'b0, 1'b0);
        step_cmd(1'b0, 2'b00, 4'd0, 4'd0);
        check_all("post_reset_hold", 4'd0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
